// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side stream adapter: the encoding of the
// output buffer occupancy and the buffer depth.
package fifo_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam int BUF_DEPTH = 2;

  // The occupancy doubles as the state of the output buffer controller.
  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_TWO   = OCC_TWO
  } occ_state_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if.sv
// Bundles the async_fifo read port and the downstream valid/ready stream.
// master = the adapter's view, slave = the FIFO/consumer side.
interface fifo_rd_stream_if #(parameter int DATA_LEN = 32);

  logic                fifo_empty_i;
  logic [DATA_LEN-1:0] fifo_data_i;
  logic                fifo_rd_en_o;
  logic                m_valid_o;
  logic                m_ready_i;
  logic [DATA_LEN-1:0] m_data_o;
  logic [1:0]          occ_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, m_ready_i,
    output fifo_rd_en_o, m_valid_o, m_data_o, occ_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, m_ready_i,
    input  fifo_rd_en_o, m_valid_o, m_data_o, occ_o
  );

endinterface

// File: rtl/fifo_rd_stream_out_buf.sv
// fifo_rd_stream_out_buf.sv
// Two-entry shift buffer (module fifo_out_buf). entry0 is the head shown to the
// consumer; a returning FIFO beat lands at the tail slot left after this
// cycle's pop, and entry1 shifts forward on the same edge.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_inflight,
  input  logic                i_popOut,
  input  logic [DATA_LEN-1:0] i_data,
  output logic [1:0]          o_occ,
  output logic [DATA_LEN-1:0] o_head
);

  occ_state_t          r_state;
  occ_state_t          w_nextState;
  logic                w_tailSel;
  logic [DATA_LEN-1:0] r_entry0;
  logic [DATA_LEN-1:0] r_entry1;

  // Occupancy register; a reset throws away everything buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_nextState;
  end

  // Next occupancy = occ + inflight - pop_out.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_EMPTY: if (i_inflight) w_nextState = ST_ONE;
      ST_ONE: begin
        if (i_popOut && !i_inflight)      w_nextState = ST_EMPTY;
        else if (i_inflight && !i_popOut) w_nextState = ST_TWO;
      end
      ST_TWO: if (i_popOut && !i_inflight) w_nextState = ST_ONE;
      default: w_nextState = ST_EMPTY;
    endcase
  end

  // Tail slot (occ - pop_out): 1 only when one beat stays behind this edge.
  always_comb begin
    w_tailSel = (r_state == ST_TWO) || ((r_state == ST_ONE) && !i_popOut);
  end

  // Shift on pop, then let the captured beat overwrite its tail slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else begin
      if (i_popOut) r_entry0 <= r_entry1;
      if (i_inflight) begin
        if (w_tailSel) r_entry1 <= i_data;
        else           r_entry0 <= i_data;
      end
    end
  end

  // A beat arriving into a full, stalled buffer would be lost.
  assert property (@(posedge clk) disable iff (!rst_n)
    !((r_state == ST_TWO) && i_inflight && !i_popOut));

  assign o_occ  = r_state;
  assign o_head = r_entry0;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream.sv
// Read-side adapter from async_fifo (read_en/empty/data_out, one-cycle read
// latency) to a valid/ready stream. Pops are issued only while the buffer plus
// the beat in flight leave room, so a returning beat always has a slot.
// Optional build macro FIFO_RD_STREAM_CNT_EN adds beat_cnt_o, a wrapping count
// of accepted output beats.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_rd_stream_if.master    bus
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]         beat_cnt_o
`endif
);

  logic       r_inflight;
  logic       w_valid;
  logic       w_popOut;
  logic       w_rdEn;
  logic [1:0] w_occ;
  logic [2:0] w_owed;

  // Beats the adapter still owes downstream after this cycle's handshake.
  always_comb begin
    w_valid  = (w_occ != OCC_EMPTY);
    w_popOut = w_valid & bus.m_ready_i;
    w_owed   = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_popOut};
    w_rdEn   = rst_n & ~bus.fifo_empty_i & (w_owed < 3'(BUF_DEPTH));
  end

  // w_rdEn already excludes empty, so it is exactly an accepted pop.
  always_ff @(posedge clk) begin
    if (!rst_n) r_inflight <= 1'b0;
    else        r_inflight <= w_rdEn;
  end

  fifo_out_buf #(.DATA_LEN(DATA_LEN)) u_outBuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inflight(r_inflight),
    .i_popOut  (w_popOut),
    .i_data    (bus.fifo_data_i),
    .o_occ     (w_occ),
    .o_head    (bus.m_data_o)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] r_beatCnt;

  // Count accepted output beats; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_beatCnt <= '0;
    else if (w_popOut) r_beatCnt <= r_beatCnt + 32'd1;
  end

  assign beat_cnt_o = r_beatCnt;
`endif

  assign bus.fifo_rd_en_o = w_rdEn;
  assign bus.m_valid_o    = w_valid;
  assign bus.occ_o        = w_occ;

endmodule
